// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch sequencer. On a fetch request accepted in IDLE it latches
// the current PC onto the memory address port, issues a one-cycle read strobe,
// waits LATENCY cycles for the synchronous memory, captures the returned word
// into the instruction register and pulses the PC-increment strobe back to
// the R7 counter.
//
// Parameters
//   LATENCY   memory read latency in cycles (1..15)
//
// Ports
//   Clock     in   system clock, rising edge
//   Clear     in   synchronous active-high reset, highest priority
//   PcValue   in   current PC from the R7 counter
//   FetchReq  in   fetch request, sampled only in IDLE
//   MemAddr   out  registered read address (latched on IDLE->ISSUE)
//   MemRd     out  read strobe, one cycle per fetch (ISSUE)
//   MemData   in   read data, valid LATENCY cycles after MemRd is sampled
//   IR        out  instruction register
//   IRValid   out  one-cycle pulse when IR has been updated (DONE)
//   IncrPc    out  one-cycle pulse to the R7 counter increment (DONE)
//   Busy      out  high in every state except IDLE
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [15:0] PcValue,
   input  logic        FetchReq,
   output logic [15:0] MemAddr,
   output logic        MemRd,
   input  logic [15:0] MemData,
   output logic [15:0] IR,
   output logic        IRValid,
   output logic        IncrPc,
   output logic        Busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(LATENCY - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [15:0] r_mem_addr;
   logic [15:0] r_ir;
   logic        r_mem_rd;
   logic        r_ir_valid;
   logic        r_incr_pc;
   logic        r_busy;

   // Strobes and Busy are registered alongside the state transition so each
   // one is high exactly while the FSM sits in its owning state.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_mem_addr <= '0;
         r_ir       <= '0;
         r_mem_rd   <= 1'b0;
         r_ir_valid <= 1'b0;
         r_incr_pc  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_mem_rd   <= 1'b0;
         r_ir_valid <= 1'b0;
         r_incr_pc  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (FetchReq) begin
                  r_mem_addr <= PcValue;
                  r_mem_rd   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= LP_CNT_INIT;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Counter is preloaded with LATENCY-1, so capture happens on
               // the LATENCY-th WAIT edge.
               if (r_cnt == 4'd0) begin
                  r_ir       <= MemData;
                  r_ir_valid <= 1'b1;
                  r_incr_pc  <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               // Always return to IDLE: PcValue is only correct there, after
               // the R7 increment lands on the edge ending DONE.
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign MemAddr = r_mem_addr;
   assign MemRd   = r_mem_rd;
   assign IR      = r_ir;
   assign IRValid = r_ir_valid;
   assign IncrPc  = r_incr_pc;
   assign Busy    = r_busy;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // DUT with LATENCY=1, PC driven by an R7 counter model
   logic        Clear1 = 1'b0;
   logic        FetchReq1 = 1'b0;
   logic [15:0] MemAddr1, IR1;
   logic        MemRd1, IRValid1, IncrPc1, Busy1;
   logic [15:0] MemData1;
   logic [15:0] r7 = 16'h0000;
   logic        r7_ld = 1'b0;
   logic [15:0] r7_val = 16'h0000;

   // DUT with LATENCY=3, PC driven directly
   logic        Clear3 = 1'b0;
   logic        FetchReq3 = 1'b0;
   logic [15:0] PcValue3 = 16'h0000;
   logic [15:0] MemAddr3, IR3;
   logic        MemRd3, IRValid3, IncrPc3, Busy3;
   logic [15:0] MemData3;

   fetch_unit #(.LATENCY(1)) u_dut1 (
      .Clock(clk), .Clear(Clear1), .PcValue(r7), .FetchReq(FetchReq1),
      .MemAddr(MemAddr1), .MemRd(MemRd1), .MemData(MemData1), .IR(IR1),
      .IRValid(IRValid1), .IncrPc(IncrPc1), .Busy(Busy1)
   );

   fetch_unit #(.LATENCY(3)) u_dut3 (
      .Clock(clk), .Clear(Clear3), .PcValue(PcValue3), .FetchReq(FetchReq3),
      .MemAddr(MemAddr3), .MemRd(MemRd3), .MemData(MemData3), .IR(IR3),
      .IRValid(IRValid3), .IncrPc(IncrPc3), .Busy(Busy3)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0010) return 16'hA5C3;
      return {a[7:0], a[15:8]} ^ 16'hC001;
   endfunction

   // Memory models: data appears LATENCY cycles after the edge sampling MemRd,
   // garbage otherwise. R7 model: load wins over increment, wraps naturally.
   logic [15:0] mp1 = 16'hDEAD;
   logic [15:0] mp3_0 = 16'hDEAD, mp3_1 = 16'hDEAD, mp3_2 = 16'hDEAD;
   assign MemData1 = mp1;
   assign MemData3 = mp3_2;

   always @(posedge clk) begin
      if (r7_ld) r7 <= r7_val;
      else if (IncrPc1) r7 <= r7 + 16'd1;
      mp1   <= MemRd1 ? mem_word(MemAddr1) : 16'hDEAD;
      mp3_0 <= MemRd3 ? mem_word(MemAddr3) : 16'hDEAD;
      mp3_1 <= mp3_0;
      mp3_2 <= mp3_1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_r7(input logic [15:0] v);
      r7_ld = 1'b1;
      r7_val = v;
      tick();
      r7_ld = 1'b0;
   endtask

   task automatic test_reset;
      Clear1 = 1'b1;
      Clear3 = 1'b1;
      tick();
      tick();
      Clear1 = 1'b0;
      Clear3 = 1'b0;
      n_cmp++;
      if ({IR1, MemAddr1, MemRd1, IRValid1, IncrPc1, Busy1} !== 36'h0) begin
         n_bad++;
         $display("FAIL reset_dut1: got %h want 0", {IR1, MemAddr1, MemRd1, IRValid1, IncrPc1, Busy1});
      end
      n_cmp++;
      if ({IR3, MemAddr3, MemRd3, IRValid3, IncrPc3, Busy3} !== 36'h0) begin
         n_bad++;
         $display("FAIL reset_dut3: got %h want 0", {IR3, MemAddr3, MemRd3, IRValid3, IncrPc3, Busy3});
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if ({Busy1, MemRd1, Busy3, MemRd3} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_idle_hold cycle %0d: got %b want 0000", c, {Busy1, MemRd1, Busy3, MemRd3});
         end
      end
   endtask

   task automatic test_single_fetch;
      load_r7(16'h0010);
      FetchReq1 = 1'b1;              // cycle 0
      tick();                        // cycle 1
      FetchReq1 = 1'b0;
      n_cmp++;
      if ({MemAddr1, MemRd1, Busy1} !== {16'h0010, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL single_issue: got addr=%h rd=%b busy=%b want addr=0010 rd=1 busy=1", MemAddr1, MemRd1, Busy1);
      end
      tick();                        // cycle 2
      n_cmp++;
      if ({MemRd1, IRValid1, IncrPc1, Busy1} !== 4'b0001) begin
         n_bad++;
         $display("FAIL single_wait: got %b want 0001", {MemRd1, IRValid1, IncrPc1, Busy1});
      end
      tick();                        // cycle 3
      n_cmp++;
      if ({IR1, IRValid1, IncrPc1} !== {16'hA5C3, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL single_done: got ir=%h v=%b inc=%b want ir=a5c3 v=1 inc=1", IR1, IRValid1, IncrPc1);
      end
      tick();                        // cycle 4
      n_cmp++;
      if ({r7, IRValid1, IncrPc1, Busy1, IR1} !== {16'h0011, 3'b000, 16'hA5C3}) begin
         n_bad++;
         $display("FAIL single_after: got r7=%h v=%b inc=%b busy=%b ir=%h want r7=0011 0 0 0 ir=a5c3", r7, IRValid1, IncrPc1, Busy1, IR1);
      end
   endtask

   task automatic test_back_to_back;
      int nrd = 0;
      int ninc = 0;
      int rd_cyc[3];
      logic [15:0] rd_addr[3];
      int exp_cyc[3];
      logic [15:0] exp_addr[3];
      exp_cyc[0] = 1;  exp_cyc[1] = 5;  exp_cyc[2] = 9;
      exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         rd_cyc[i] = -1;
         rd_addr[i] = 16'hXXXX;
      end
      load_r7(16'hFFFE);
      FetchReq1 = 1'b1;              // cycle 0
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 12) FetchReq1 = 1'b0;
         if (MemRd1 === 1'b1) begin
            if (nrd < 3) begin
               rd_cyc[nrd] = c;
               rd_addr[nrd] = MemAddr1;
            end
            nrd++;
         end
         if (IncrPc1 === 1'b1) ninc++;
      end
      FetchReq1 = 1'b0;
      n_cmp++;
      if (nrd != 3) begin
         n_bad++;
         $display("FAIL b2b_reads: got %0d want 3", nrd);
      end
      n_cmp++;
      if (ninc != 3) begin
         n_bad++;
         $display("FAIL b2b_incr: got %0d want 3", ninc);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (rd_cyc[i] != exp_cyc[i] || rd_addr[i] !== exp_addr[i]) begin
            n_bad++;
            $display("FAIL b2b_issue%0d: got cycle %0d addr %h want cycle %0d addr %h", i, rd_cyc[i], rd_addr[i], exp_cyc[i], exp_addr[i]);
         end
      end
      n_cmp++;
      if (r7 !== 16'h0001) begin
         n_bad++;
         $display("FAIL b2b_r7_final: got %h want 0001", r7);
      end
   endtask

   task automatic test_latency3;
      int nrd = 0;
      int nval = 0;
      int val_cyc = -1;
      logic [15:0] ir_at = 16'h0000;
      PcValue3 = 16'h0040;
      FetchReq3 = 1'b1;              // cycle 0
      for (int c = 1; c <= 9; c++) begin
         tick();
         FetchReq3 = (c <= 5);
         if (c == 2) PcValue3 = 16'h0777;
         if (MemRd3 === 1'b1) nrd++;
         if (IRValid3 === 1'b1) begin
            nval++;
            val_cyc = c;
            ir_at = IR3;
            n_cmp++;
            if (IncrPc3 !== 1'b1) begin
               n_bad++;
               $display("FAIL lat3_incr: got %b want 1", IncrPc3);
            end
         end
         if (c == 1) begin
            n_cmp++;
            if (MemAddr3 !== 16'h0040) begin
               n_bad++;
               $display("FAIL lat3_addr: got %h want 0040", MemAddr3);
            end
         end
         if (c == 6) begin
            n_cmp++;
            if (Busy3 !== 1'b0) begin
               n_bad++;
               $display("FAIL lat3_idle: got busy=%b want 0", Busy3);
            end
         end
      end
      FetchReq3 = 1'b0;
      n_cmp++;
      if (nrd != 1) begin
         n_bad++;
         $display("FAIL lat3_reads: got %0d want 1", nrd);
      end
      n_cmp++;
      if (nval != 1 || val_cyc != 5) begin
         n_bad++;
         $display("FAIL lat3_valid: got count %0d cycle %0d want count 1 cycle 5", nval, val_cyc);
      end
      n_cmp++;
      if (ir_at !== mem_word(16'h0040)) begin
         n_bad++;
         $display("FAIL lat3_ir: got %h want %h", ir_at, mem_word(16'h0040));
      end
   endtask

   task automatic test_abort;
      int npulse;
      // abort in WAIT
      load_r7(16'h0030);
      FetchReq1 = 1'b1;              // cycle 0
      tick();                        // cycle 1
      FetchReq1 = 1'b0;
      tick();                        // cycle 2 (WAIT)
      Clear1 = 1'b1;
      tick();                        // cycle 3
      Clear1 = 1'b0;
      n_cmp++;
      if ({IR1, MemAddr1, MemRd1, IRValid1, IncrPc1, Busy1} !== 36'h0) begin
         n_bad++;
         $display("FAIL abort_wait_clear: got %h want 0", {IR1, MemAddr1, MemRd1, IRValid1, IncrPc1, Busy1});
      end
      npulse = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (IRValid1 !== 1'b0 || IncrPc1 !== 1'b0 || Busy1 !== 1'b0) npulse++;
      end
      n_cmp++;
      if (npulse != 0 || r7 !== 16'h0030) begin
         n_bad++;
         $display("FAIL abort_wait_after: got activity=%0d r7=%h want activity=0 r7=0030", npulse, r7);
      end
      // abort in DONE
      FetchReq1 = 1'b1;              // cycle 0
      tick();                        // cycle 1
      FetchReq1 = 1'b0;
      tick();                        // cycle 2
      tick();                        // cycle 3 (DONE)
      n_cmp++;
      if (IRValid1 !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_done_reach: got IRValid=%b want 1", IRValid1);
      end
      Clear1 = 1'b1;
      tick();                        // cycle 4
      Clear1 = 1'b0;
      n_cmp++;
      if ({IR1, MemAddr1, MemRd1, IRValid1, IncrPc1, Busy1} !== 36'h0) begin
         n_bad++;
         $display("FAIL abort_done_clear: got %h want 0", {IR1, MemAddr1, MemRd1, IRValid1, IncrPc1, Busy1});
      end
      npulse = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (IRValid1 !== 1'b0 || IncrPc1 !== 1'b0 || Busy1 !== 1'b0) npulse++;
      end
      n_cmp++;
      if (npulse != 0) begin
         n_bad++;
         $display("FAIL abort_done_after: got activity=%0d want 0", npulse);
      end
      // recovery fetch
      load_r7(16'h0050);
      FetchReq1 = 1'b1;
      tick();
      FetchReq1 = 1'b0;
      tick();
      tick();                        // DONE
      n_cmp++;
      if ({IR1, IRValid1, IncrPc1} !== {mem_word(16'h0050), 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL abort_recover: got ir=%h v=%b inc=%b want ir=%h v=1 inc=1", IR1, IRValid1, IncrPc1, mem_word(16'h0050));
      end
      tick();
   endtask

   task automatic test_pc_disturb;
      load_r7(16'h0020);
      FetchReq1 = 1'b1;              // cycle 0
      tick();                        // cycle 1
      FetchReq1 = 1'b0;
      n_cmp++;
      if (MemAddr1 !== 16'h0020) begin
         n_bad++;
         $display("FAIL disturb_issue_addr: got %h want 0020", MemAddr1);
      end
      r7_ld = 1'b1;                  // R7 shows 0x0100 from cycle 2
      r7_val = 16'h0100;
      tick();                        // cycle 2
      r7_ld = 1'b0;
      tick();                        // cycle 3
      n_cmp++;
      if ({IR1, MemAddr1, IncrPc1} !== {mem_word(16'h0020), 16'h0020, 1'b1}) begin
         n_bad++;
         $display("FAIL disturb_done: got ir=%h addr=%h inc=%b want ir=%h addr=0020 inc=1", IR1, MemAddr1, IncrPc1, mem_word(16'h0020));
      end
      tick();                        // cycle 4 (IDLE)
      n_cmp++;
      if (r7 !== 16'h0101 || Busy1 !== 1'b0) begin
         n_bad++;
         $display("FAIL disturb_r7: got r7=%h busy=%b want r7=0101 busy=0", r7, Busy1);
      end
      FetchReq1 = 1'b1;
      tick();                        // cycle 5
      FetchReq1 = 1'b0;
      n_cmp++;
      if ({MemAddr1, MemRd1} !== {16'h0101, 1'b1}) begin
         n_bad++;
         $display("FAIL disturb_next_addr: got addr=%h rd=%b want addr=0101 rd=1", MemAddr1, MemRd1);
      end
      tick();
      tick();
      n_cmp++;
      if (IR1 !== mem_word(16'h0101)) begin
         n_bad++;
         $display("FAIL disturb_next_ir: got %h want %h", IR1, mem_word(16'h0101));
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      #2;
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_latency3();
      test_abort();
      test_pc_disturb();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
